// File: rtl/dmem_port_arbiter.sv
// Shares single-port DataMemory between the pipeline MEM stage (priority) and an
// auxiliary req/ack master, with a starvation counter that forces one aux slot.
module dmem_port_arbiter #(
  parameter int MEM_BYTES    = 4096,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pipe_valid,
  input  logic        pipe_we,
  input  logic [31:0] pipe_addr,
  input  logic [31:0] pipe_wdata,
  output logic        pipe_stall,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic        aux_ack,
  output logic        aux_err,
  output logic [31:0] aux_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {IDLE, ACK} state_t;

  state_t      state_q, state_d;
  logic [7:0]  starve_q, starve_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic idle, err_cond, aux_grant, aux_accept;

  always_comb begin
    idle       = (state_q == IDLE);
    err_cond   = (aux_addr >= 32'(MEM_BYTES)) || (aux_addr[1:0] != 2'b00);
    // Reset gates the grant so a reset-cycle access never reaches memory or acks.
    aux_grant  = !reset && idle && aux_req && !err_cond &&
                 (!pipe_valid || starve_q == 8'(STARVE_LIMIT));
    aux_accept = !reset && idle && aux_req && (err_cond || aux_grant);

    state_d = state_q;
    case (state_q)
      IDLE:    if (aux_accept) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    starve_d = starve_q;
    if (aux_accept || !aux_req)
      starve_d = 8'd0;
    else if (idle && starve_q != 8'(STARVE_LIMIT))
      starve_d = starve_q + 8'd1;

    ack_d   = aux_accept;
    err_d   = aux_accept && err_cond;
    rdata_d = rdata_q;
    if (aux_accept)
      rdata_d = (err_cond || aux_we) ? 32'd0 : mem_rdata;
  end

  always_comb begin
    mem_we     = !reset && (aux_grant ? aux_we : (pipe_valid && pipe_we));
    mem_addr   = aux_grant ? aux_addr  : pipe_addr;
    mem_wdata  = aux_grant ? aux_wdata : pipe_wdata;
    pipe_stall = pipe_valid && aux_grant;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= 8'd0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign aux_ack   = ack_q;
  assign aux_err   = err_q;
  assign aux_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios then random traffic, checked
// against a cycle-level behavioural model with a shadow copy of memory.
module tb_dmem_port_arbiter;

  localparam int LIMIT = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        pipe_valid, pipe_we;
  logic [31:0] pipe_addr, pipe_wdata;
  logic        pipe_stall;
  logic        aux_req, aux_we;
  logic [31:0] aux_addr, aux_wdata;
  logic        aux_ack, aux_err;
  logic [31:0] aux_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clock = ~clock;

  dmem_port_arbiter #(.MEM_BYTES(4096), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_we(pipe_we), .pipe_addr(pipe_addr),
    .pipe_wdata(pipe_wdata), .pipe_stall(pipe_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ack(aux_ack), .aux_err(aux_err), .aux_rdata(aux_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // DataMemory: combinational read, synchronous write
  logic [31:0] dram [0:1023];
  assign mem_rdata = dram[mem_addr[11:2]];
  always @(posedge clock) if (mem_we) dram[mem_addr[11:2]] <= mem_wdata;

  // Reference model state
  logic [31:0] shadow [0:1023];
  int          m_wait;
  bit          m_in_ack;
  logic        exp_ack, exp_err;
  logic [31:0] exp_rdata;
  logic        prev_ack;
  logic        last_stall;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit          err, grant, acc, e_we;
    logic [31:0] e_addr, e_wdata;
    #1;
    err     = (aux_addr >= 32'd4096) || (aux_addr % 4 != 0);
    grant   = !reset && !m_in_ack && aux_req && !err && (!pipe_valid || m_wait >= LIMIT);
    e_we    = reset ? 1'b0 : (grant ? aux_we : (pipe_valid && pipe_we));
    e_addr  = grant ? aux_addr  : pipe_addr;
    e_wdata = grant ? aux_wdata : pipe_wdata;
    chk("pipe_stall", {31'd0, pipe_stall}, {31'd0, pipe_valid && grant});
    chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
    chk("mem_addr", mem_addr, e_addr);
    if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
    last_stall = pipe_stall;
    prev_ack   = aux_ack;
    @(posedge clock);
    if (reset) begin
      m_in_ack = 0; m_wait = 0;
      exp_ack = 0; exp_err = 0; exp_rdata = 0;
    end else begin
      acc = !m_in_ack && aux_req && (err || grant);
      if (acc) exp_rdata = (err || aux_we) ? 32'd0 : shadow[aux_addr[11:2]];
      exp_ack = acc;
      exp_err = acc && err;
      if (e_we) shadow[e_addr[11:2]] = e_wdata;
      if (acc || !aux_req) m_wait = 0;
      else if (!m_in_ack) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
      m_in_ack = acc;
    end
    #1;
    chk("aux_ack", {31'd0, aux_ack}, {31'd0, exp_ack});
    chk("aux_err", {31'd0, aux_err}, {31'd0, exp_err});
    chk("aux_rdata", aux_rdata, exp_rdata);
    chk("ack_gap", {31'd0, aux_ack && prev_ack}, 32'd0);
  endtask

  task automatic wait_ack(input string tag);
    int n;
    for (n = 0; n < 40; n++) begin
      step();
      if (aux_ack) break;
    end
    chk(tag, {31'd0, n < 40}, 32'd1);
  endtask

  task automatic aux_set(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    aux_req = req; aux_we = we; aux_addr = a; aux_wdata = d;
  endtask

  initial begin
    int  n;
    bit  busy;
    for (int i = 0; i < 1024; i++) begin dram[i] = 32'd0; shadow[i] = 32'd0; end
    m_wait = 0; m_in_ack = 0; exp_ack = 0; exp_err = 0; exp_rdata = 0;
    prev_ack = 0; last_stall = 0;
    reset = 1;
    pipe_valid = 1; pipe_we = 1; pipe_addr = 32'h20; pipe_wdata = 32'h5555_0000;
    aux_set(1, 1, 32'h40, 32'hDEAD_BEEF);
    #2;
    // Reset with both masters requesting: no write, grant discarded
    step(); step();
    reset = 0; pipe_valid = 0; pipe_we = 0;
    aux_set(0, 0, 32'h0, 32'h0);
    step();
    chk("reset_rdata", aux_rdata, 32'd0);

    // Idle pipe: aux write, then aux read back-to-back (req held through ACK)
    aux_set(1, 1, 32'h40, 32'h0000_1234);
    wait_ack("wr_ack");
    chk("wr_rdata", aux_rdata, 32'd0);
    aux_set(1, 0, 32'h40, 32'h0);
    step();
    chk("b2b_no_ack", {31'd0, aux_ack}, 32'd0);
    wait_ack("rd_ack");
    chk("rd_rdata", aux_rdata, 32'h0000_1234);
    aux_set(0, 0, 32'h0, 32'h0);
    step();

    // Reset asserted during the ack cycle
    aux_set(1, 0, 32'h40, 32'h0);
    wait_ack("pre_rst_ack");
    aux_set(0, 0, 32'h0, 32'h0);
    reset = 1; pipe_valid = 1; pipe_we = 1;
    step();
    chk("rst_ack", {31'd0, aux_ack}, 32'd0);
    chk("rst_rdata", aux_rdata, 32'd0);
    reset = 0; pipe_valid = 0; pipe_we = 0;
    step();

    // Starvation: pipe busy every cycle, forced grant on the 9th cycle
    pipe_valid = 1; pipe_we = 0; pipe_addr = 32'h100;
    aux_set(1, 0, 32'h10, 32'h0);
    for (n = 1; n <= 20; n++) begin
      step();
      if (last_stall) break;
    end
    chk("starve_wait", n, LIMIT + 1);
    chk("starve_ack", {31'd0, aux_ack}, 32'd1);
    aux_set(0, 0, 32'h0, 32'h0);
    step();
    chk("starve_stall_once", {31'd0, last_stall}, 32'd0);
    pipe_valid = 0;
    step();

    // Error acceptances: out of range, then unaligned
    aux_set(1, 0, 32'h2000, 32'h0);
    wait_ack("oor_ack");
    chk("oor_err", {31'd0, aux_err}, 32'd1);
    aux_set(1, 1, 32'h42, 32'h1111_2222);
    step();
    wait_ack("unal_ack");
    chk("unal_err", {31'd0, aux_err}, 32'd1);
    chk("unal_rdata", aux_rdata, 32'd0);
    aux_set(0, 0, 32'h0, 32'h0);
    step();
    chk("err_clear", {31'd0, aux_err}, 32'd0);

    // Pipe store collides with aux read of the same word
    pipe_valid = 1; pipe_we = 1; pipe_addr = 32'h80; pipe_wdata = 32'hAAAA_AAAA;
    aux_set(1, 0, 32'h80, 32'h0);
    step();
    chk("coll_no_grant", {31'd0, aux_ack}, 32'd0);
    pipe_valid = 0; pipe_we = 0;
    wait_ack("coll_ack");
    chk("coll_rdata", aux_rdata, 32'hAAAA_AAAA);
    aux_set(0, 0, 32'h0, 32'h0);
    step();

    // Random traffic
    busy = 0;
    for (int c = 0; c < 600; c++) begin
      pipe_valid = ($urandom_range(0, 9) < 7);
      pipe_we    = $urandom_range(0, 1);
      pipe_addr  = {20'd0, 10'($urandom), 2'b00};
      pipe_wdata = $urandom;
      if (!busy) begin
        if ($urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 9))
            0:       aux_addr = 32'h1000 + {20'd0, 10'($urandom), 2'b00};
            1:       aux_addr = {20'd0, 10'($urandom), 2'($urandom_range(1, 3))};
            default: aux_addr = {20'd0, 10'($urandom), 2'b00};
          endcase
          aux_req = 1; aux_we = $urandom_range(0, 1); aux_wdata = $urandom;
          busy = 1;
        end else begin
          aux_req = 0;
        end
      end
      step();
      if (aux_ack) busy = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
